// File: rtl/gene_attractor_finder_pkg.sv
// Shared types and constants for the gene-network attractor finder:
// result-kind encodings, the control FSM state type and update-rule selectors.
package gene_net_pkg;

    // Result classification reported on res_kind.
    localparam logic [1:0] KIND_FIXED = 2'b00;
    localparam logic [1:0] KIND_CYCLE = 2'b01;
    localparam logic [1:0] KIND_OVF   = 2'b10;

    // Update-rule selectors for the MODE parameter.
    localparam int MODE_ROTL   = 0;
    localparam int MODE_RULE90 = 1;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/gene_attractor_finder_rule.sv
// Combinational next-state function of the gene network.
// MODE_ROTL   : rotate-left ring.
// MODE_RULE90 : x'[i] = x[(i-1) mod N] ^ x[(i+1) mod N].
module gene_net_rule
    import gene_net_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_ROTL
) (
    input  logic [N-1:0] i_x,
    output logic [N-1:0] o_nx
);

    // Select the ring update at elaboration time; only one rule is built.
    if (MODE == MODE_RULE90) begin : g_rule90
        for (genvar i = 0; i < N; i++) begin : g_bit
            assign o_nx[i] = i_x[(i + N - 1) % N] ^ i_x[(i + 1) % N];
        end
    end else begin : g_rotl
        assign o_nx = {i_x[N-2:0], i_x[N-1]};
    end

endmodule

// File: rtl/gene_attractor_finder.sv
// Gene-network attractor finder: iterates a Boolean ring network from an
// initial state, keeps every visited state in a history buffer and reports
// the first revisited state as a fixed point, a cycle, or overflow when no
// state repeats within D steps.
// Optional feature macro: GENE_SWEEP_EN adds sweep_go / sweep_done, which
// classify every initial value 0 .. 2^N-1 in order through the result port.
module gene_attractor_finder
    import gene_net_pkg::*;
#(
    parameter int N    = 8,
    parameter int D    = 16,
    parameter int MODE = MODE_ROTL
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef GENE_SWEEP_EN
    input  logic                   sweep_go,
    output logic                   sweep_done,
`endif
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [N-1:0]           init_val,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [1:0]             res_kind,
    output logic [N-1:0]           res_init,
    output logic [N-1:0]           res_state,
    output logic [$clog2(D+1)-1:0] res_cyc_len,
    output logic [$clog2(D+1)-1:0] res_trans_len
);

    localparam int CW = $clog2(D + 1);
    localparam int IW = $clog2(D);
    localparam logic [CW-1:0] DEPTH = CW'(D);

    state_t        r_state;
    state_t        w_state_next;
    logic [N-1:0]  r_x;
    logic [N-1:0]  w_nx;
    logic [N-1:0]  w_launch_val;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_hit_idx;
    logic [CW-1:0] w_cyc_len;
    logic          w_hit;
    logic          w_launch;
    logic          w_start_ready;
    logic          w_res_hs;
    logic          w_grow;
    logic [N-1:0]  r_hist [D];

    logic [1:0]    r_res_kind;
    logic [N-1:0]  r_res_init;
    logic [N-1:0]  r_res_state;
    logic [CW-1:0] r_res_cyc;
    logic [CW-1:0] r_res_trans;

`ifdef GENE_SWEEP_EN
    logic          r_sweep_active;
    logic          r_sweep_done;
    logic [N-1:0]  r_sweep_val;
`endif

    gene_net_rule #(
        .N    (N),
        .MODE (MODE)
    ) u_rule (
        .i_x  (r_x),
        .o_nx (w_nx)
    );

    assign w_res_hs  = (r_state == ST_REPORT) && res_ready;
    assign w_cyc_len = r_count - w_hit_idx;
    assign w_grow    = (r_state == ST_STEP) && !w_hit && (r_count != DEPTH);

    // Launch arbitration: decides whether IDLE starts a run and with what value.
    always_comb begin
        w_launch      = 1'b0;
        w_launch_val  = init_val;
        w_start_ready = 1'b0;
`ifdef GENE_SWEEP_EN
        // A running sweep, or a sweep_go, takes the slot ahead of start_valid.
        if (r_state == ST_IDLE) begin
            if (r_sweep_active) begin
                w_launch     = 1'b1;
                w_launch_val = r_sweep_val;
            end else if (sweep_go) begin
                w_launch     = 1'b1;
                w_launch_val = '0;
            end else begin
                w_start_ready = 1'b1;
                w_launch      = start_valid;
            end
        end
`else
        if (r_state == ST_IDLE) begin
            w_start_ready = 1'b1;
            w_launch      = start_valid;
        end
`endif
    end

    // Parallel compare of the next state against all valid history entries.
    // History entries are distinct, so at most one index can match.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = 0; k < D; k++) begin
            if ((CW'(k) < r_count) && (r_hist[k] == w_nx)) begin
                w_hit     = 1'b1;
                w_hit_idx = CW'(k);
            end
        end
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; a hit wins over overflow on the last step.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_launch) w_state_next = ST_STEP;
            ST_STEP:   if (w_hit || (r_count == DEPTH)) w_state_next = ST_REPORT;
            ST_REPORT: if (res_ready) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Run datapath: current state, step count and the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x         <= '0;
            r_count     <= '0;
            r_res_kind  <= KIND_FIXED;
            r_res_init  <= '0;
            r_res_state <= '0;
            r_res_cyc   <= '0;
            r_res_trans <= '0;
        end else if (w_launch) begin
            r_x        <= w_launch_val;
            r_count    <= CW'(1);
            r_res_init <= w_launch_val;
        end else if (r_state == ST_STEP) begin
            if (w_hit) begin
                r_res_state <= w_nx;
                r_res_trans <= w_hit_idx;
                r_res_cyc   <= w_cyc_len;
                r_res_kind  <= (w_cyc_len == CW'(1)) ? KIND_FIXED : KIND_CYCLE;
            end else if (r_count == DEPTH) begin
                r_res_state <= w_nx;
                r_res_trans <= DEPTH;
                r_res_cyc   <= '0;
                r_res_kind  <= KIND_OVF;
            end else begin
                r_x     <= w_nx;
                r_count <= r_count + CW'(1);
            end
        end
    end

    // History buffer writes: entry 0 at launch, then one entry per miss.
    // NOTE: the history array has no reset; entries at or above r_count are never compared.
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_hist[0] <= w_launch_val;
        end else if (w_grow) begin
            r_hist[r_count[IW-1:0]] <= w_nx;
        end
    end

`ifdef GENE_SWEEP_EN
    // Sweep sequencer: walks init values 0 .. 2^N-1, one run per handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep_active <= 1'b0;
            r_sweep_done   <= 1'b0;
            r_sweep_val    <= '0;
        end else begin
            r_sweep_done <= 1'b0;
            if ((r_state == ST_IDLE) && !r_sweep_active && sweep_go) begin
                r_sweep_active <= 1'b1;
                r_sweep_val    <= '0;
            end else if (w_res_hs && r_sweep_active) begin
                if (r_sweep_val == {N{1'b1}}) begin
                    r_sweep_active <= 1'b0;
                    r_sweep_done   <= 1'b1;
                end else begin
                    r_sweep_val <= r_sweep_val + N'(1);
                end
            end
        end
    end

    assign sweep_done = r_sweep_done;
`endif

    assign start_ready   = w_start_ready;
    assign res_valid     = (r_state == ST_REPORT);
    assign res_kind      = r_res_kind;
    assign res_init      = r_res_init;
    assign res_state     = r_res_state;
    assign res_cyc_len   = r_res_cyc;
    assign res_trans_len = r_res_trans;

endmodule

// File: tb/tb_gene_attractor_finder.sv
// Scoreboard bench for gene_attractor_finder. Several configurations are
// instantiated side by side: unit 0 MODE=0 D=16, unit 1 MODE=1 D=16,
// unit 2 MODE=0 D=4, and with GENE_SWEEP_EN unit 3 N=4 MODE=0 D=16.
// Drivers push hand-computed expected results; a monitor pops on handshake.
module tb_gene_attractor_finder;

    import gene_net_pkg::*;

`ifdef GENE_SWEEP_EN
    localparam int NU = 4;
`else
    localparam int NU = 3;
`endif

    function automatic int unit_n(int g);
        return (g == 3) ? 4 : 8;
    endfunction
    function automatic int unit_d(int g);
        return (g == 2) ? 4 : 16;
    endfunction
    function automatic int unit_mode(int g);
        return (g == 1) ? MODE_RULE90 : MODE_ROTL;
    endfunction

    typedef struct {
        int         unit;
        logic [1:0] kind;
        logic [7:0] init;
        logic [7:0] state;
        logic [7:0] cyc;
        logic [7:0] trans;
        int         lat;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid [NU];
    logic       start_ready [NU];
    logic       res_valid   [NU];
    logic       res_ready   [NU];
    logic [7:0] init_val    [NU];
    logic [1:0] res_kind    [NU];
    logic [7:0] res_init    [NU];
    logic [7:0] res_state   [NU];
    logic [7:0] res_cyc     [NU];
    logic [7:0] res_trans   [NU];
`ifdef GENE_SWEEP_EN
    logic       sweep_go    [NU];
    logic       sweep_done  [NU];
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   hs_cnt   [NU];
    int   hs_cyc   [NU];
    int   done_cnt [NU];
    int   done_cyc [NU];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : u
        localparam int GN = unit_n(g);
        localparam int GD = unit_d(g);
        localparam int GM = unit_mode(g);
        localparam int GC = $clog2(GD + 1);
        logic [GN-1:0] l_init, l_rinit, l_state;
        logic [GC-1:0] l_cyc, l_trans;

        assign l_init = init_val[g][GN-1:0];

        gene_attractor_finder #(
            .N    (GN),
            .D    (GD),
            .MODE (GM)
        ) dut (
            .clk           (clk),
            .rst           (rst),
`ifdef GENE_SWEEP_EN
            .sweep_go      (sweep_go[g]),
            .sweep_done    (sweep_done[g]),
`endif
            .start_valid   (start_valid[g]),
            .start_ready   (start_ready[g]),
            .init_val      (l_init),
            .res_valid     (res_valid[g]),
            .res_ready     (res_ready[g]),
            .res_kind      (res_kind[g]),
            .res_init      (l_rinit),
            .res_state     (l_state),
            .res_cyc_len   (l_cyc),
            .res_trans_len (l_trans)
        );

        assign res_init[g]  = 8'(l_rinit);
        assign res_state[g] = 8'(l_state);
        assign res_cyc[g]   = 8'(l_cyc);
        assign res_trans[g] = 8'(l_trans);
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Cycle counter, advanced on each active edge.
    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Monitor: latency at res_valid rise, stability while held, fields at handshake.
    initial begin
        logic       prev_v [NU];
        logic       unstable [NU];
        logic [1:0] cap_kind [NU];
        logic [7:0] cap_init [NU], cap_state [NU], cap_cyc [NU], cap_trans [NU];
        exp_t       e;
        for (int i = 0; i < NU; i++) begin
            prev_v[i] = 1'b0;
            unstable[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NU; i++) begin
                if (rst) begin
                    prev_v[i] = 1'b0;
                    continue;
                end
`ifdef GENE_SWEEP_EN
                if (sweep_done[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc_cnt;
                end
`endif
                if (res_valid[i] && !prev_v[i]) begin
                    if (sb.size() == 0 || sb[0].unit != i) begin
                        fail_now($sformatf("u%0d_unexpected_res_valid", i));
                    end else if (sb[0].lat >= 0) begin
                        check($sformatf("u%0d_latency_init%02h", i, sb[0].init),
                              cyc_cnt - sb[0].acc, sb[0].lat);
                    end
                    cap_kind[i]  = res_kind[i];
                    cap_init[i]  = res_init[i];
                    cap_state[i] = res_state[i];
                    cap_cyc[i]   = res_cyc[i];
                    cap_trans[i] = res_trans[i];
                    unstable[i]  = 1'b0;
                end else if (res_valid[i]) begin
                    if (cap_kind[i] != res_kind[i] || cap_init[i] != res_init[i] ||
                        cap_state[i] != res_state[i] || cap_cyc[i] != res_cyc[i] ||
                        cap_trans[i] != res_trans[i])
                        unstable[i] = 1'b1;
                end
                if (res_valid[i] && res_ready[i]) begin
                    hs_cnt[i]++;
                    hs_cyc[i] = cyc_cnt;
                    if (sb.size() != 0 && sb[0].unit == i) begin
                        e = sb.pop_front();
                        check($sformatf("u%0d_kind_init%02h", i, e.init), int'(res_kind[i]), int'(e.kind));
                        check($sformatf("u%0d_res_init_init%02h", i, e.init), int'(res_init[i]), int'(e.init));
                        check($sformatf("u%0d_state_init%02h", i, e.init), int'(res_state[i]), int'(e.state));
                        check($sformatf("u%0d_cyc_init%02h", i, e.init), int'(res_cyc[i]), int'(e.cyc));
                        check($sformatf("u%0d_trans_init%02h", i, e.init), int'(res_trans[i]), int'(e.trans));
                        check($sformatf("u%0d_stable_init%02h", i, e.init), int'(unstable[i]), 0);
                    end
                end
                prev_v[i] = res_valid[i];
            end
        end
    end

    task automatic wait_ready(int un, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (start_ready[un]) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int un, logic [7:0] iv, logic [1:0] k, logic [7:0] st,
                        logic [7:0] cy, logic [7:0] tr, int lat);
        bit   ok;
        exp_t e;
        wait_ready(un, ok);
        if (!ok) begin
            fail_now($sformatf("u%0d_start_ready_timeout", un));
            return;
        end
        init_val[un]    = iv;
        start_valid[un] = 1'b1;
        @(posedge clk);
        #1;
        start_valid[un] = 1'b0;
        e.unit = un; e.kind = k; e.init = iv; e.state = st;
        e.cyc = cy; e.trans = tr; e.lat = lat; e.acc = cyc_cnt;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit ok;
        bit bad;
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit bad;
        rst = 1'b1;
        for (int i = 0; i < NU; i++) begin
            start_valid[i] = 1'b0;
            res_ready[i]   = 1'b1;
            init_val[i]    = 8'h00;
            hs_cnt[i]      = 0;
            hs_cyc[i]      = 0;
            done_cnt[i]    = 0;
            done_cyc[i]    = 0;
`ifdef GENE_SWEEP_EN
            sweep_go[i]    = 1'b0;
`endif
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, observed in the first cycle after reset.
        for (int i = 0; i < NU; i++) begin
            check($sformatf("u%0d_reset_start_ready", i), int'(start_ready[i]), 1);
            check($sformatf("u%0d_reset_res_valid", i), int'(res_valid[i]), 0);
        end
        check("reset_res_kind", int'(res_kind[0]), 0);
        check("reset_res_init", int'(res_init[0]), 0);
        check("reset_res_state", int'(res_state[0]), 0);
        check("reset_res_cyc", int'(res_cyc[0]), 0);
        check("reset_res_trans", int'(res_trans[0]), 0);

        // MODE=0, D=16: fixed points and rotation cycles.
        send(0, 8'h00, KIND_FIXED, 8'h00, 8'd1, 8'd0, 1);
        send(0, 8'h11, KIND_CYCLE, 8'h11, 8'd4, 8'd0, 4);
        send(0, 8'h55, KIND_CYCLE, 8'h55, 8'd2, 8'd0, 2);
        send(0, 8'hFF, KIND_FIXED, 8'hFF, 8'd1, 8'd0, 1);
        send(0, 8'h01, KIND_CYCLE, 8'h01, 8'd8, 8'd0, 8);
        drain();

        // MODE=1 (rule 90), D=16: transients into the all-zero fixed point.
        send(1, 8'h01, KIND_FIXED, 8'h00, 8'd1, 8'd4, 5);
        send(1, 8'hFF, KIND_FIXED, 8'h00, 8'd1, 8'd1, 2);
        drain();

        // MODE=0, D=4: overflow, and a hit on the very last step beating overflow.
        send(2, 8'h01, KIND_OVF,   8'h10, 8'd0, 8'd4, 4);
        send(2, 8'h11, KIND_CYCLE, 8'h11, 8'd4, 8'd0, 4);
        send(2, 8'h03, KIND_OVF,   8'h30, 8'd0, 8'd4, 4);
        drain();

        // Back-pressure: hold res_ready low for 10 cycles once the result is up.
        res_ready[0] = 1'b0;
        send(0, 8'h11, KIND_CYCLE, 8'h11, 8'd4, 8'd0, 4);
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(posedge clk);
            #1;
            ok = res_valid[0];
        end
        if (!ok) fail_now("hold_res_valid_timeout");
        bad = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1;
            if (start_ready[0] || !res_valid[0]) bad = 1'b1;
        end
        check("hold_start_ready_low_valid_high", int'(bad), 0);
        res_ready[0] = 1'b1;
        drain();

        // Reset mid-run: the run is dropped without a result.
        wait_ready(0, ok);
        init_val[0]    = 8'h01;
        start_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        start_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pulse_rst();
        check("midrun_rst_start_ready", int'(start_ready[0]), 1);
        bad = 1'b0;
        for (int t = 0; t < 15; t++) begin
            @(posedge clk);
            #1;
            if (res_valid[0]) bad = 1'b1;
        end
        check("midrun_rst_no_res_valid", int'(bad), 0);

        // Reset while in REPORT: the pending result is discarded.
        res_ready[0] = 1'b0;
        send(0, 8'h55, KIND_CYCLE, 8'h55, 8'd2, 8'd0, 2);
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(posedge clk);
            #1;
            ok = res_valid[0];
        end
        if (!ok) fail_now("report_res_valid_timeout");
        pulse_rst();
        sb.delete();
        res_ready[0] = 1'b1;
        check("report_rst_res_valid", int'(res_valid[0]), 0);
        check("report_rst_start_ready", int'(start_ready[0]), 1);
        check("report_rst_res_cyc", int'(res_cyc[0]), 0);
        check("report_rst_res_state", int'(res_state[0]), 0);
        bad = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk);
            #1;
            if (res_valid[0]) bad = 1'b1;
        end
        check("report_rst_no_res_valid", int'(bad), 0);

        // Recovery after reset.
        send(0, 8'h55, KIND_CYCLE, 8'h55, 8'd2, 8'd0, 2);
        drain();

`ifdef GENE_SWEEP_EN
        // Sweep on the N=4 rotate-left unit with random back-pressure.
        for (int v = 0; v < 16; v++) begin
            exp_t e;
            e.unit = 3; e.init = 8'(v); e.state = 8'(v); e.trans = 8'd0;
            e.lat = -1; e.acc = 0;
            if (v == 0 || v == 15) begin
                e.kind = KIND_FIXED; e.cyc = 8'd1;
            end else if (v == 5 || v == 10) begin
                e.kind = KIND_CYCLE; e.cyc = 8'd2;
            end else begin
                e.kind = KIND_CYCLE; e.cyc = 8'd4;
            end
            sb.push_back(e);
        end
        wait_ready(3, ok);
        sweep_go[3] = 1'b1;
        @(posedge clk);
        #1;
        sweep_go[3] = 1'b0;
        bad = 1'b0;
        for (int t = 0; t < 3000 && hs_cnt[3] < 16; t++) begin
            if (start_ready[3]) bad = 1'b1;
            res_ready[3] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        res_ready[3] = 1'b1;
        check("sweep_start_ready_low", int'(bad), 0);
        check("sweep_handshakes", hs_cnt[3], 16);
        repeat (3) @(posedge clk);
        #1;
        check("sweep_done_pulses", done_cnt[3], 1);
        check("sweep_done_timing", done_cyc[3], hs_cyc[3] + 1);
        check("sweep_scoreboard_empty", sb.size(), 0);
        sb.delete();
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gene_attractor_finder.md
GENE_ATTRACTOR_FINDER -- requirements
Module: gene_attractor_finder

Interface
REQ-001 Parameter N, default 8, network width in genes; legal 2..16.
REQ-002 Parameter D, default 16, history depth in states; legal 2..256.
REQ-003 Parameter MODE, default 0, update rule: 0 = rotate-left ring; 1 = rule-90 ring, x'[i] = x[(i-1) mod N] XOR x[(i+1) mod N].
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start_valid  in  1  request to classify init_val.
REQ-008 start_ready  out  1  block idle and able to accept a request.
REQ-009 init_val  in  N  initial network state.
REQ-010 res_valid  out  1  result available.
REQ-011 res_ready  in  1  consumer accepts result.
REQ-012 res_kind  out  2  00 fixed point, 01 cycle, 10 overflow (no repeat within D states).
REQ-013 res_init  out  N  init_val of the classified run.
REQ-014 res_state  out  N  first repeated state (attractor entry); last computed state on overflow.
REQ-015 res_cyc_len  out  clog2(D+1)  attractor length in states.
REQ-016 res_trans_len  out  clog2(D+1)  transient length in states before the attractor.

Function
REQ-017 The FSM SHALL have states IDLE, STEP, REPORT; start_ready = (state == IDLE).
REQ-018 In IDLE, start_valid high SHALL load history[0] = init_val, x = init_val, count = 1, and move to STEP on the same edge.
REQ-019 Each STEP cycle SHALL compute nx = f(x) and compare it in parallel against history[0..count-1].
REQ-020 On a hit at index k, the block SHALL set res_state = nx, res_trans_len = k, res_cyc_len = count - k, res_kind = 00 if count - k == 1 else 01, and move to REPORT.
REQ-021 On a miss with count == D, the block SHALL set res_kind = 10, res_state = nx, res_cyc_len = 0, res_trans_len = D, and move to REPORT.
REQ-022 On a miss with count < D, the block SHALL write history[count] = nx, set x = nx, and increment count.
REQ-023 A hit SHALL take priority over overflow when both occur on the step where count == D.
REQ-024 res_valid SHALL rise exactly trans_len + cyc_len cycles after the accepting edge, or D cycles after it on overflow.
REQ-025 In REPORT, res_valid SHALL stay high and all res_* outputs SHALL stay stable until res_valid && res_ready, then the FSM returns to IDLE.
REQ-026 A new request SHALL be accepted no earlier than the cycle after the result handshake; start_valid is ignored outside IDLE.

Reset
REQ-027 rst SHALL force IDLE, count = 0, and all res_* outputs = 0, with start_ready high on the first cycle after reset.
REQ-028 rst asserted mid-run or during REPORT SHALL abort the run and discard the result, with no res_valid pulse.

Configuration
REQ-029 With GENE_SWEEP_EN defined, the block SHALL add input sweep_go (1) and output sweep_done (1).
REQ-030 Under GENE_SWEEP_EN, sweep_go in IDLE SHALL classify init values 0..2^N-1 in ascending order through the same result handshake, with start_ready held low during the sweep.
REQ-031 Under GENE_SWEEP_EN, sweep_done SHALL pulse for one cycle, the cycle after the result for 2^N-1 is handshaken.
REQ-032 Without GENE_SWEEP_EN, the sweep_go and sweep_done ports and the sweep logic SHALL be absent.

Structure
REQ-033 Package gene_net_pkg SHALL hold the res_kind encodings (KIND_FIXED, KIND_CYCLE, KIND_OVF), the FSM state enum, and the MODE constants.
REQ-034 Sub-module gene_net_rule SHALL be the combinational next-state function, parameterised by N and MODE, and instantiated once.

Verification
REQ-035 MODE=0, N=8: init 0x00 -> kind 00, state 0x00, cyc 1, trans 0, res_valid 1 cycle after accept.
REQ-036 MODE=0, N=8: init 0x11 -> kind 01, state 0x11, cyc 4, trans 0, res_valid 4 cycles after accept; init 0x55 -> kind 01, cyc 2.
REQ-037 MODE=1, N=8: init 0x01 (path 01, 82, 44, AA, 00) -> kind 00, state 0x00, trans 4, cyc 1, res_valid 5 cycles after accept.
REQ-038 MODE=0, N=8, D=4: init 0x01 -> kind 10, trans 4, res_valid 4 cycles after accept.
REQ-039 Hold res_ready low for 10 cycles -> res_* outputs stable and start_ready low throughout; rst pulsed mid-run -> no res_valid, start_ready high the next cycle.
REQ-040 GENE_SWEEP_EN, N=4, MODE=0 -> 16 results with res_init 0..15 in order, res_ready toggled randomly; sweep_done pulses once after the final handshake.
